posit_divider: RTL and testbench

POSIT_DIVIDER -- requirements
Module: posit_divider

---
 rtl/posit_divider_pkg.sv | 31 +++
 rtl/posit_divider_data_extraction.sv | 47 ++++
 rtl/posit_divider.sv | 220 ++++++++++++++++++++++
 tb/tb_posit_divider.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_divider_pkg.sv
// Shared posit definitions: divider FSM states and the special bit patterns
// (NaR, zero, maxpos, minpos) for any posit width up to PMAX bits.
package posit_divider_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    DIVIDE,
    ROUND,
    DONE
  } div_state_t;

  localparam int PMAX = 64;

  localparam logic [PMAX-1:0] POSIT_ZERO = '0;

  // Callers truncate these to their own width with an N'() cast.
  function automatic logic [PMAX-1:0] nar_pattern(input int n);
    nar_pattern = '0;
    nar_pattern[n-1] = 1'b1;
  endfunction

  function automatic logic [PMAX-1:0] maxpos_pattern(input int n);
    maxpos_pattern = nar_pattern(n) - PMAX'(1);
  endfunction

  function automatic logic [PMAX-1:0] minpos_pattern(input int n);
    minpos_pattern = (n > 1) ? PMAX'(1) : '0;
  endfunction

endpackage

// File: rtl/posit_divider_data_extraction.sv
// Combinational posit field decoder: sign, regime value k, exponent and
// mantissa with the hidden bit at the MSB. Zero and NaR are handled by the caller.
module Data_Extraction
  import posit_divider_pkg::*;
#(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N)
) (
  input  logic [N-1:0]       in_posit,
  output logic               sign,
  output logic signed [RS:0] regime,
  output logic [ES-1:0]      exponent,
  output logic [N-1:0]       mantissa
);

  localparam logic [RS:0] RS_ONE = 1;

  logic [N-2:0] body;
  logic [N-2:0] rest;
  logic [N-2:0] frac;
  logic         lead;
  logic         stop;
  logic [RS:0]  run;

  always_comb begin
    sign = in_posit[N-1];
    // Only the bits below the sign survive the two's-complement magnitude.
    body = sign ? -in_posit[N-2:0] : in_posit[N-2:0];
    lead = body[N-2];
    run  = '0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && (body[i] == lead)) begin
        run = run + RS_ONE;
      end else begin
        stop = 1'b1;
      end
    end
    regime   = lead ? $signed(run - RS_ONE) : -$signed(run);
    rest     = body << (run + RS_ONE);
    exponent = rest[N-2 -: ES];
    frac     = rest << ES;
    mantissa = {1'b1, frac};
  end

endmodule

// File: rtl/posit_divider.sv
// Multi-cycle posit divider: decode, restoring mantissa division (one bit per
// cycle), round-to-nearest-even re-encode, then a valid/ready output hold.
module posit_divider
  import posit_divider_pkg::*;
#(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] IN1,
  input  logic [N-1:0] IN2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] OUT,
  output logic         div_by_zero
);

  localparam int SW = RS + ES + 2;
  localparam int QW = N + 3;
  localparam int BW = 2 * N + ES + 4;
  localparam int CW = $clog2(N + 3);

  localparam logic [N-1:0] NAR    = N'(nar_pattern(N));
  localparam logic [N-1:0] ZERO   = N'(POSIT_ZERO);
  localparam logic [N-1:0] MAXPOS = N'(maxpos_pattern(N));
  localparam logic [N-1:0] MINPOS = N'(minpos_pattern(N));

  localparam logic [CW-1:0] DIV_LAST = CW'(N + 2);
  localparam logic [CW-1:0] CNT_ONE  = 1;

  localparam logic signed [RS+1:0] K_HI = (RS + 2)'(N - 2);
  localparam logic signed [RS+1:0] K_LO = (RS + 2)'(-(N - 1));

  div_state_t             state_reg;
  logic                   in_ready_reg;
  logic                   out_valid_reg;
  logic [N-1:0]           out_reg;
  logic                   dbz_reg;
  logic [N-1:0]           a_reg;
  logic [N-1:0]           b_reg;
  logic                   sign_reg;
  logic signed [SW-1:0]   scale_reg;
  logic [N-1:0]           div_reg;
  logic [N:0]             rem_reg;
  logic [QW-1:0]          q_reg;
  logic [CW-1:0]          cnt_reg;

  logic                   sign_a;
  logic                   sign_b;
  logic signed [RS:0]     regime_a;
  logic signed [RS:0]     regime_b;
  logic [ES-1:0]          exp_a;
  logic [ES-1:0]          exp_b;
  logic [N-1:0]           mant_a;
  logic [N-1:0]           mant_b;

  Data_Extraction #(.N(N), .ES(ES), .RS(RS)) u_extract_a (
    .in_posit (a_reg),
    .sign     (sign_a),
    .regime   (regime_a),
    .exponent (exp_a),
    .mantissa (mant_a)
  );

  Data_Extraction #(.N(N), .ES(ES), .RS(RS)) u_extract_b (
    .in_posit (b_reg),
    .sign     (sign_b),
    .regime   (regime_b),
    .exponent (exp_b),
    .mantissa (mant_b)
  );

  logic signed [SW-1:0] scale_a;
  logic signed [SW-1:0] scale_b;

  // {k, e} concatenated is exactly k * 2^ES + e; sign-extend by one bit.
  assign scale_a = {regime_a[RS], regime_a, exp_a};
  assign scale_b = {regime_b[RS], regime_b, exp_b};

  logic [N+1:0]          frac_next;
  logic signed [SW-1:0]  scale_adj;
  logic signed [RS+1:0]  k_res;
  logic [ES-1:0]         e_res;
  logic [RS+1:0]         shamt;
  logic [BW-1:0]         body;
  logic [N-2:0]          mag;
  logic                  guard_bit;
  logic                  round_bit;
  logic                  sticky_bit;
  logic                  round_up;
  logic [N-1:0]          mag_inc;
  logic [N-1:0]          rounded;
  logic [N-1:0]          result_next;

  always_comb begin
    // A quotient below 1 is left-normalised and costs one from the scale.
    frac_next = q_reg[QW-1] ? q_reg[N+1:0] : {q_reg[N:0], 1'b0};
    scale_adj = scale_reg - {{(SW-1){1'b0}}, ~q_reg[QW-1]};
    k_res     = scale_adj[SW-1:ES];
    e_res     = scale_adj[ES-1:0];
    shamt     = k_res[RS+1] ? ~k_res : k_res;
    // Regime as a run: ones-then-zero sign-filled for k >= 0, zeros-then-one for k < 0.
    if (k_res[RS+1]) begin
      body = {2'b01, e_res, frac_next, {N{1'b0}}} >> shamt;
    end else begin
      body = $signed({2'b10, e_res, frac_next, {N{1'b0}}}) >>> shamt;
    end
    mag        = body[BW-1 -: N-1];
    guard_bit  = body[BW-N];
    round_bit  = body[BW-N-1];
    sticky_bit = (|body[BW-N-2:0]) | (|rem_reg);
    round_up   = guard_bit & (mag[0] | round_bit | sticky_bit);
    mag_inc    = {1'b0, mag} + {{(N-1){1'b0}}, round_up};
    if ((k_res >= K_HI) || mag_inc[N-1]) begin
      rounded = MAXPOS;
    end else if ((k_res <= K_LO) || (mag_inc == ZERO)) begin
      rounded = MINPOS;
    end else begin
      rounded = mag_inc;
    end
    result_next = sign_reg ? -rounded : rounded;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      dbz_reg       <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      sign_reg      <= 1'b0;
      scale_reg     <= '0;
      div_reg       <= '0;
      rem_reg       <= '0;
      q_reg         <= '0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_reg        <= IN1;
            b_reg        <= IN2;
            in_ready_reg <= 1'b0;
            state_reg    <= DECODE;
          end else begin
            in_ready_reg <= 1'b1;
          end
        end
        DECODE: begin
          if ((a_reg == NAR) || (b_reg == NAR)) begin
            out_reg       <= NAR;
            dbz_reg       <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else if (b_reg == ZERO) begin
            out_reg       <= NAR;
            dbz_reg       <= 1'b1;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else if (a_reg == ZERO) begin
            out_reg       <= ZERO;
            dbz_reg       <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            sign_reg  <= sign_a ^ sign_b;
            scale_reg <= scale_a - scale_b;
            div_reg   <= mant_b;
            rem_reg   <= {1'b0, mant_a};
            q_reg     <= '0;
            cnt_reg   <= DIV_LAST;
            state_reg <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (rem_reg >= {1'b0, div_reg}) begin
            rem_reg <= (rem_reg - {1'b0, div_reg}) << 1;
            q_reg   <= {q_reg[QW-2:0], 1'b1};
          end else begin
            rem_reg <= rem_reg << 1;
            q_reg   <= {q_reg[QW-2:0], 1'b0};
          end
          if (cnt_reg == '0) begin
            state_reg <= ROUND;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        ROUND: begin
          out_reg       <= result_next;
          dbz_reg       <= 1'b0;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign OUT         = out_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_posit_divider.sv
// Self-checking bench for posit_divider (N=8, ES=3): directed cases, handshake
// hold, mid-operation reset, then random operands against a value-level model.
module tb_posit_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] IN1;
  logic [7:0] IN2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] OUT;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  posit_divider #(.N(8), .ES(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .IN1         (IN1),
    .IN2         (IN2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .OUT         (OUT),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Posit value as mantissa m (hidden bit at bit 7, i.e. value m/128) times 2^sc.
  function automatic void decode_posit(input logic [7:0] p, output int sc, output longint m);
    logic [7:0] a;
    logic       lead;
    int         i, run, k, e;
    a    = p[7] ? -p : p;
    lead = a[6];
    run  = 0;
    i    = 6;
    while (i >= 0 && a[i] == lead) begin
      run++;
      i--;
    end
    k = lead ? run - 1 : -run;
    i--;
    e = 0;
    for (int j = 0; j < 3; j++) begin
      e = 2 * e + ((i >= 0 && a[i]) ? 1 : 0);
      i--;
    end
    m = 1;
    for (int j = 0; j < 7; j++) begin
      m = 2 * m + ((i >= 0 && a[i]) ? 1 : 0);
      i--;
    end
    sc = 8 * k + e;
  endfunction

  function automatic void ref_divide(input logic [7:0] a, input logic [7:0] b,
                                     output logic [7:0] q, output logic dbz);
    int         sa, sb, scale, k, e, hb;
    longint     ma, mb, num, quo, r;
    bit         bits[$];
    logic [7:0] mag;
    bit         guard, sticky;
    dbz = 1'b0;
    q   = 8'h00;
    if (a == 8'h80 || b == 8'h80) begin
      q = 8'h80;
    end else if (b == 8'h00) begin
      q   = 8'h80;
      dbz = 1'b1;
    end else if (a == 8'h00) begin
      q = 8'h00;
    end else begin
      decode_posit(a, sa, ma);
      decode_posit(b, sb, mb);
      scale = sa - sb;
      num   = ma <<< 40;
      quo   = num / mb;
      r     = num % mb;
      hb    = 40;
      if (quo < (longint'(1) <<< 40)) begin
        hb = 39;
        scale--;
      end
      k = (scale >= 0) ? scale / 8 : -((7 - scale) / 8);
      e = scale - 8 * k;
      if (k >= 6) begin
        mag = 8'h7F;
      end else if (k <= -7) begin
        mag = 8'h01;
      end else begin
        if (k >= 0) begin
          for (int j = 0; j <= k; j++) bits.push_back(1'b1);
          bits.push_back(1'b0);
        end else begin
          for (int j = 0; j < -k; j++) bits.push_back(1'b0);
          bits.push_back(1'b1);
        end
        for (int j = 2; j >= 0; j--) bits.push_back(bit'((e >> j) & 1));
        for (int j = hb - 1; j >= 0; j--) bits.push_back(quo[j]);
        mag = 8'h00;
        for (int j = 0; j < 7; j++) mag = {mag[6:0], bits[j]};
        guard  = bits[7];
        sticky = (r != 0);
        for (int j = 8; j < bits.size(); j++) sticky |= bits[j];
        if (guard && (mag[0] || sticky)) mag = mag + 8'd1;
        if (mag == 8'h80) mag = 8'h7F;
        if (mag == 8'h00) mag = 8'h01;
      end
      q = (a[7] ^ b[7]) ? -mag : mag;
    end
  endfunction

  // One full transaction: offer operands, time out_valid from the accepting
  // edge, optionally stall the consumer for 'hold' cycles, then consume.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit early_rdy,
                        input int hold, input logic [7:0] exp_out, input logic exp_dbz,
                        input int exp_lat);
    int         waited;
    int         lat;
    logic [7:0] res;
    logic       dbz;
    @(negedge clk);
    IN1       = a;
    IN2       = b;
    in_valid  = 1'b1;
    out_ready = early_rdy;
    waited    = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("accept_%02h_%02h", a, b), in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
    res = OUT;
    dbz = div_by_zero;
    check($sformatf("lat_%02h_%02h", a, b), lat, exp_lat);
    check($sformatf("out_%02h_%02h", a, b), res, exp_out);
    check($sformatf("dbz_%02h_%02h", a, b), dbz, exp_dbz);
    for (int h = 0; h < hold; h++) begin
      IN1      = 8'($urandom);
      IN2      = 8'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_valid", h), out_valid, 1);
      check($sformatf("hold%0d_out", h), OUT, exp_out);
      check($sformatf("hold%0d_dbz", h), div_by_zero, exp_dbz);
      check($sformatf("hold%0d_in_ready", h), in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check($sformatf("released_%02h_%02h", a, b), out_valid, 0);
    $display("op %02h / %02h -> %02h dbz=%0d lat=%0d (model %02h dbz=%0d)",
             a, b, res, dbz, lat, exp_out, exp_dbz);
  endtask

  logic [7:0] dir_a   [9] = '{8'h48, 8'h40, 8'hC0, 8'h40, 8'h7F, 8'h01, 8'h40, 8'h00, 8'h80};
  logic [7:0] dir_b   [9] = '{8'h44, 8'h44, 8'h40, 8'h46, 8'h01, 8'h7F, 8'h00, 8'h44, 8'h40};
  logic [7:0] dir_out [9] = '{8'h44, 8'h3C, 8'hC0, 8'h39, 8'h7F, 8'h01, 8'h80, 8'h00, 8'h80};
  logic       dir_dbz [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  int         dir_lat [9] = '{13, 13, 13, 13, 13, 13, 1, 1, 1};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb, rq;
    logic       rdbz;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    IN1       = 8'h00;
    IN2       = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", OUT, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_in_ready", in_ready, 1);

    for (int t = 0; t < 9; t++) begin
      run_op(dir_a[t], dir_b[t], 1'b0, 0, dir_out[t], dir_dbz[t], dir_lat[t]);
    end

    // Consumer stalls five cycles in DONE while new operands are offered.
    run_op(8'h48, 8'h44, 1'b0, 5, 8'h44, 1'b0, 13);

    // Reset in the middle of DIVIDE: outputs clear at once, no result appears.
    @(negedge clk);
    IN1      = 8'h48;
    IN2      = 8'h44;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out", OUT, 0);
    check("abort_dbz", div_by_zero, 0);
    check("abort_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_release_in_ready", in_ready, 1);
    check("abort_release_out_valid", out_valid, 0);
    run_op(8'h40, 8'h46, 1'b0, 0, 8'h39, 1'b0, 13);

    for (int t = 0; t < 250; t++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (t % 10 == 0) rb = 8'h00;
      if (t % 13 == 0) ra = 8'h00;
      ref_divide(ra, rb, rq, rdbz);
      run_op(ra, rb, bit'($urandom_range(0, 1)), 0, rq, rdbz,
             (ra == 8'h00 || rb == 8'h00 || ra == 8'h80 || rb == 8'h80) ? 1 : 13);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
